mask_stream_seq: RTL and testbench
==================================

Name: mask_stream_seq

Overview:
Sequential mask producer that drives the per-element mask side of the vector mask datapath.
- Walks a source mask register (v0 or vs2) from element 0 to vl-1, LANES elements per beat.
- Fetches 32-bit mask words through a read port.
- Emits per-lane mask bits, the exclusive running set-bit count (viota source), the element index (vid source), and the final popcount.
- Sits between the vector register file mask read port and the lane mask/iota/offset inputs.

Parameters:
LANES, 4, elements emitted per beat; must divide 32 (1, 2, 4, 8).
VLMAX, 256, maximum vl; IDXW = $clog2(VLMAX)+1 (9 by default).

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
start  in  1  begin a pass; accepted only when busy=0
abort  in  1  cancel the current pass
vl  in  IDXW  element count, sampled on start
vm  in  1  1 = unmasked: all mask bits read as 1 and no fetches are issued
mask_ren  out  1  mask word read request
mask_raddr  out  IDXW-5  mask word index
mask_rdata  in  32  read data, valid the cycle after mask_ren
out_valid  out  1  beat valid
out_ready  in  1  consumer accepts the beat
out_mask  out  LANES  per-lane mask bit; 0 for tail lanes (index >= vl)
out_iota  out  LANES*IDXW  per-lane count of set bits at indices below the lane
out_offset  out  LANES*IDXW  per-lane element index
out_last  out  1  beat contains element vl-1
busy  out  1  pass in progress
done  out  1  one-cycle pulse at pass completion
popc  out  IDXW  total set bits among elements 0..vl-1; held until the next start

Behaviour:
- Reset: state IDLE; all outputs 0, including popc; counters and buffers cleared.
- FSM states: IDLE, FETCH, LOAD, STREAM, DONE.
- IDLE:
  - start with vl=0 -> DONE. No fetch and no beats.
  - start with vm=1 -> STREAM, word buffer forced to all ones.
  - otherwise -> FETCH.
- FETCH: mask_ren=1, mask_raddr=word_idx -> LOAD.
- LOAD: capture mask_rdata into the word buffer -> STREAM. The first out_valid therefore occurs 3 cycles after start in the masked case.
- STREAM:
  - out_valid=1 every cycle in this state.
  - Outputs are a function of registered state only and stay stable while out_ready=0.
  - On handshake, elem_idx += LANES and running_cnt += popcount of that beat's non-tail mask bits.
  - Lane i values: mask = buffer bit [(elem_idx mod 32)+i] & (elem_idx+i < vl); iota = running_cnt + count of set, non-tail bits in lanes below i; offset = elem_idx+i.
  - Handshake on the out_last beat -> DONE.
  - Handshake on the last beat of a word with more elements remaining -> FETCH for word_idx+1 (vm=0), or stay in STREAM (vm=1).
- DONE: done=1 for exactly one cycle; popc = running_cnt -> IDLE. busy=0 in IDLE only.
- abort: in any non-IDLE state, returns to IDLE the next cycle. out_valid drops, no done pulse, popc not updated, any outstanding read data ignored.
- start while busy: ignored. abort and start in the same IDLE cycle: abort wins.
- Arithmetic: all counters are IDXW bits; vl=VLMAX does not overflow; vl > VLMAX is not supported.

Optional Feature:
MASK_PREFETCH_EN
- Defined:
  - Adds a second 32-bit word buffer.
  - During STREAM, the next word is fetched when a next word exists and the second buffer is empty; the data is captured the following cycle.
  - At a word boundary with the second buffer full, streaming continues with no bubble.
  - Both buffers are cleared on abort and on DONE.
- Undefined: a 2-cycle bubble (FETCH, LOAD) at every word boundary, as described in Behaviour.

Decomposition:
- Package rv32v types: mask_seq_state_t enum (IDLE, FETCH, LOAD, STREAM, DONE) and the constant MASK_WORD_W=32.
- One sub-module, mask_prefix_count: a combinational LANES-wide exclusive prefix sum plus total popcount of the beat bits. It is instanced once.

Test Plan:
- vl=0, vm=0, start -> no mask_ren, no out_valid; done pulses 1 cycle after start; popc=0.
- vm=1, vl=10, LANES=4 -> 3 beats; offsets 0..11; out_mask 1111, 1111, 0011; iota 0..9; out_last on beat 3; popc=10; mask_ren never asserted.
- vm=0, vl=8, word0=0x000000A5 -> beat0 mask 0101, iota {0,1,1,2}; beat1 mask 1010, iota {2,2,3,3}; popc=4; mask_raddr=0 only.
- Same as the previous scenario with out_ready held low for 5 cycles mid-pass -> outputs constant while stalled; the sequence after release matches the unstalled run.
- vm=0, vl=40, word0=0xFFFFFFFF, word1=0x1 -> reads at raddr 0 then 1; 2 idle cycles between beats 8 and 9 (0 with MASK_PREFETCH_EN); popc=33.
- abort asserted during the 2nd beat -> next cycle IDLE, busy=0, no done, popc keeps its previous value; a subsequent start runs normally.

Source files
------------

// File: rtl/mask_stream_seq_pkg.sv
// Shared types for the sequential mask producer: FSM state encoding and the
// mask word width fetched from the register file.
package mask_stream_seq_pkg;
    localparam int MASK_WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        STREAM,
        DONE
    } mask_seq_state_t;
endpackage

// File: rtl/mask_stream_seq_if.sv
// Mask read port plus per-beat lane output stream of mask_stream_seq.
// A beat transfers on a rising CLK edge where out_valid && out_ready; while
// out_valid is high and out_ready low, every out_* field holds steady.
interface mask_stream_seq_if #(
    parameter int LANES = 4,
    parameter int IDXW  = 9
);
    logic                  mask_ren;
    logic [IDXW-6:0]       mask_raddr;
    logic [31:0]           mask_rdata;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES-1:0]      out_mask;
    logic [LANES*IDXW-1:0] out_iota;
    logic [LANES*IDXW-1:0] out_offset;
    logic                  out_last;

    modport master (
        output mask_ren, mask_raddr, out_valid, out_mask, out_iota, out_offset, out_last,
        input  mask_rdata, out_ready
    );

    modport slave (
        input  mask_ren, mask_raddr, out_valid, out_mask, out_iota, out_offset, out_last,
        output mask_rdata, out_ready
    );
endinterface

// File: rtl/mask_stream_seq_prefix_count.sv
// Exclusive prefix sum of the beat's lane bits and their total popcount.
module mask_prefix_count #(
    parameter int LANES = 4,
    parameter int CW    = 9
) (
    input  logic [LANES-1:0]    bits,
    output logic [LANES*CW-1:0] prefix,
    output logic [CW-1:0]       total
);
    logic [CW-1:0] acc;

    always_comb begin
        acc    = '0;
        prefix = '0;
        for (int i = 0; i < LANES; i++) begin
            prefix[i*CW +: CW] = acc;
            acc = acc + CW'(bits[i]);
        end
        total = acc;
    end
endmodule

// File: rtl/mask_stream_seq.sv
// Walks a source mask from element 0 to vl-1, LANES elements per beat, emitting
// mask/iota/offset per lane. Define MASK_PREFETCH_EN to hide word-boundary bubbles.
module mask_stream_seq
    import mask_stream_seq_pkg::*;
#(
    parameter int LANES = 4,
    parameter int VLMAX = 256,
    localparam int IDXW  = $clog2(VLMAX) + 1,
    localparam int WIDXW = IDXW - 5
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic             abort,
    input  logic [IDXW-1:0]  vl,
    input  logic             vm,
    mask_stream_seq_if.master bus,
    output logic             busy,
    output logic             done,
    output logic [IDXW-1:0]  popc,
    output mask_seq_state_t  dbg_state
);
    mask_seq_state_t  state_q, state_d;
    logic [IDXW-1:0]  vl_q, vl_d;
    logic             vm_q, vm_d;
    logic [WIDXW-1:0] word_idx_q, word_idx_d;
    logic [IDXW-1:0]  elem_idx_q, elem_idx_d;
    logic [IDXW-1:0]  run_cnt_q, run_cnt_d;
    logic [MASK_WORD_W-1:0] buf0_q, buf0_d;
    logic [IDXW-1:0]  popc_q, popc_d;

    logic [LANES-1:0]      beat_bits;
    logic [LANES*IDXW-1:0] beat_prefix;
    logic [IDXW-1:0]       beat_total;
    logic [LANES*IDXW-1:0] lane_iota;
    logic [LANES*IDXW-1:0] lane_offset;
    logic                  streaming;
    logic                  beat_last;
    logic                  word_end;

`ifdef MASK_PREFETCH_EN
    logic [MASK_WORD_W-1:0] buf1_q, buf1_d;
    logic                   buf1_full_q, buf1_full_d;
    logic                   pf_pend_q, pf_pend_d;
    logic [IDXW-1:0]        next_base;
    logic                   pf_req;

    // Fetch the following word into the spare buffer as soon as one exists.
    assign next_base = {word_idx_q + WIDXW'(1), 5'b00000};
    assign pf_req    = (state_q == STREAM) && !vm_q && !buf1_full_q && !pf_pend_q &&
                       (vl_q > next_base);
`endif

    assign streaming = (state_q == STREAM);
    assign beat_last = (elem_idx_q + IDXW'(LANES)) >= vl_q;
    assign word_end  = (elem_idx_q[4:0] == 5'(MASK_WORD_W - LANES));

    always_comb begin
        beat_bits   = '0;
        lane_offset = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_offset[i*IDXW +: IDXW] = elem_idx_q + IDXW'(i);
            beat_bits[i] = buf0_q[elem_idx_q[4:0] + 5'(i)] & ((elem_idx_q + IDXW'(i)) < vl_q);
        end
    end

    mask_prefix_count #(.LANES(LANES), .CW(IDXW)) u_prefix (
        .bits   (beat_bits),
        .prefix (beat_prefix),
        .total  (beat_total)
    );

    always_comb begin
        lane_iota = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_iota[i*IDXW +: IDXW] = run_cnt_q + beat_prefix[i*IDXW +: IDXW];
        end
    end

    always_comb begin
        state_d    = state_q;
        vl_d       = vl_q;
        vm_d       = vm_q;
        word_idx_d = word_idx_q;
        elem_idx_d = elem_idx_q;
        run_cnt_d  = run_cnt_q;
        buf0_d     = buf0_q;
        popc_d     = popc_q;
`ifdef MASK_PREFETCH_EN
        buf1_d      = buf1_q;
        buf1_full_d = buf1_full_q;
        pf_pend_d   = pf_req;
        if (pf_pend_q) begin
            buf1_d      = bus.mask_rdata;
            buf1_full_d = 1'b1;
        end
`endif
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    vl_d       = vl;
                    vm_d       = vm;
                    word_idx_d = '0;
                    elem_idx_d = '0;
                    run_cnt_d  = '0;
                    if (vl == '0) begin
                        state_d = DONE;
                        popc_d  = '0;
                    end else if (vm) begin
                        state_d = STREAM;
                        buf0_d  = '1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                buf0_d  = bus.mask_rdata;
                state_d = STREAM;
            end
            STREAM: begin
                if (bus.out_ready) begin
                    elem_idx_d = elem_idx_q + IDXW'(LANES);
                    run_cnt_d  = run_cnt_q + beat_total;
                    if (beat_last) begin
                        state_d = DONE;
                        popc_d  = run_cnt_q + beat_total;
                    end else if (word_end && !vm_q) begin
                        word_idx_d = word_idx_q + WIDXW'(1);
`ifdef MASK_PREFETCH_EN
                        // Prefer the spare buffer, then data in flight, then a read
                        // issued this very cycle (its data lands during LOAD).
                        if (buf1_full_q) begin
                            buf0_d      = buf1_q;
                            buf1_full_d = 1'b0;
                        end else if (pf_pend_q) begin
                            buf0_d      = bus.mask_rdata;
                            buf1_full_d = 1'b0;
                        end else if (pf_req) begin
                            state_d   = LOAD;
                            pf_pend_d = 1'b0;
                        end else begin
                            state_d = FETCH;
                        end
`else
                        state_d = FETCH;
`endif
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort drops the pass outright: no done, popc and read data untouched.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            buf0_d  = buf0_q;
            popc_d  = popc_q;
        end
`ifdef MASK_PREFETCH_EN
        if ((abort && (state_q != IDLE)) || (state_q == DONE)) begin
            buf1_d      = '0;
            buf1_full_d = 1'b0;
            pf_pend_d   = 1'b0;
        end
`endif
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            vl_q       <= '0;
            vm_q       <= 1'b0;
            word_idx_q <= '0;
            elem_idx_q <= '0;
            run_cnt_q  <= '0;
            buf0_q     <= '0;
            popc_q     <= '0;
`ifdef MASK_PREFETCH_EN
            buf1_q      <= '0;
            buf1_full_q <= 1'b0;
            pf_pend_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            vl_q       <= vl_d;
            vm_q       <= vm_d;
            word_idx_q <= word_idx_d;
            elem_idx_q <= elem_idx_d;
            run_cnt_q  <= run_cnt_d;
            buf0_q     <= buf0_d;
            popc_q     <= popc_d;
`ifdef MASK_PREFETCH_EN
            buf1_q      <= buf1_d;
            buf1_full_q <= buf1_full_d;
            pf_pend_q   <= pf_pend_d;
`endif
        end
    end

`ifdef MASK_PREFETCH_EN
    assign bus.mask_ren   = (state_q == FETCH) || pf_req;
    assign bus.mask_raddr = streaming ? (word_idx_q + WIDXW'(1)) : word_idx_q;
`else
    assign bus.mask_ren   = (state_q == FETCH);
    assign bus.mask_raddr = word_idx_q;
`endif

    assign bus.out_valid  = streaming;
    assign bus.out_mask   = streaming ? beat_bits   : '0;
    assign bus.out_iota   = streaming ? lane_iota   : '0;
    assign bus.out_offset = streaming ? lane_offset : '0;
    assign bus.out_last   = streaming && beat_last;

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign popc      = popc_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_mask_stream_seq.sv
// Directed bench for mask_stream_seq: unmasked, masked, stalled, two-word,
// vl=0 and abort passes against hand-computed beats.
`timescale 1ns/1ps
module tb_mask_stream_seq;
    import mask_stream_seq_pkg::*;

    localparam int LANES = 4;
    localparam int VLMAX = 256;
    localparam int IDXW  = 9;
    localparam int BW    = 1 + LANES + 2*LANES*IDXW;
`ifdef MASK_PREFETCH_EN
    localparam int EXP_GAP = 0;
`else
    localparam int EXP_GAP = 2;
`endif

    // clock / reset
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            vm    = 1'b0;
    logic [IDXW-1:0] vl    = '0;
    logic            busy;
    logic            done;
    logic [IDXW-1:0] popc;
    mask_seq_state_t dbg_state;

    mask_stream_seq_if #(.LANES(LANES), .IDXW(IDXW)) bus ();

    mask_stream_seq #(.LANES(LANES), .VLMAX(VLMAX)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .start     (start),
        .abort     (abort),
        .vl        (vl),
        .vm        (vm),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .popc      (popc),
        .dbg_state (dbg_state)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // mask register file model: data one cycle after the request
    logic [31:0] mem [16];
    always @(posedge CLK) begin
        if (!nRST) bus.mask_rdata <= '0;
        else if (bus.mask_ren) bus.mask_rdata <= mem[bus.mask_raddr];
    end

    // scoreboard state, filled by the monitor away from the active edge
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] obs_q[$];
    int beat_cyc_q[$];
    int rd_q[$];
    int done_cnt, done_cyc, start_cyc, first_valid_cyc;

    always @(negedge CLK) begin
        if (nRST) begin
            if (start && !busy && !abort) start_cyc = cyc;
            if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.out_valid && bus.out_ready) begin
                obs_q.push_back({bus.out_last, bus.out_mask, bus.out_iota, bus.out_offset});
                beat_cyc_q.push_back(cyc);
            end
            if (bus.mask_ren) rd_q.push_back(int'(bus.mask_raddr));
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // driver tasks
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_mon();
        exp_q.delete();
        obs_q.delete();
        beat_cyc_q.delete();
        rd_q.delete();
        done_cnt        = 0;
        done_cyc        = -1;
        start_cyc       = -1;
        first_valid_cyc = -1;
    endtask

    task automatic start_pass(input int v, input logic m);
        vl    = IDXW'(v);
        vm    = m;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (done_cnt == 0) begin
            bad++;
            $display("FAIL wait_done: no done pulse within %0d cycles", budget);
        end
        tick();
        tick();
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!bus.out_valid && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (!bus.out_valid) begin
            bad++;
            $display("FAIL wait_valid: out_valid not seen within %0d cycles", budget);
        end
    endtask

    function automatic logic [BW-1:0] mk_beat(input logic last, input logic [3:0] m,
                                              input int i0, input int i1, input int i2,
                                              input int i3, input int off0);
        logic [LANES*IDXW-1:0] io;
        logic [LANES*IDXW-1:0] of;
        io = {IDXW'(i3), IDXW'(i2), IDXW'(i1), IDXW'(i0)};
        of = {IDXW'(off0 + 3), IDXW'(off0 + 2), IDXW'(off0 + 1), IDXW'(off0)};
        return {last, m, io, of};
    endfunction

    // scenarios
    task automatic test_reset();
        nRST = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_0000 | i;
        tick(); tick(); tick();
        total++;
        if ({busy, done, bus.out_valid, bus.mask_ren, bus.out_last} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000",
                     {busy, done, bus.out_valid, bus.mask_ren, bus.out_last});
        end
        total++;
        if (popc !== '0) begin
            bad++;
            $display("FAIL reset_popc: got %0d want 0", popc);
        end
        nRST = 1'b1;
        tick();
        total++;
        if (dbg_state !== IDLE) begin
            bad++;
            $display("FAIL reset_state: got %0d want IDLE", dbg_state);
        end
        total++;
        if ({bus.out_mask, bus.out_iota, bus.out_offset} !== '0) begin
            bad++;
            $display("FAIL reset_lanes: got %h want 0", {bus.out_mask, bus.out_iota, bus.out_offset});
        end
    endtask

    task automatic test_unmasked();
        clear_mon();
        start_pass(10, 1'b1);
        wait_done(50);
        exp_q.push_back(mk_beat(1'b0, 4'b1111, 0, 1, 2, 3, 0));
        exp_q.push_back(mk_beat(1'b0, 4'b1111, 4, 5, 6, 7, 4));
        exp_q.push_back(mk_beat(1'b1, 4'b0011, 8, 9, 10, 10, 8));
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL unmasked_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            total++;
            if (obs_q[k] !== exp_q[k]) begin
                bad++;
                $display("FAIL unmasked_beat%0d: got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
        total++;
        if (popc !== 9'd10) begin bad++; $display("FAIL unmasked_popc: got %0d want 10", popc); end
        total++;
        if (rd_q.size() != 0) begin bad++; $display("FAIL unmasked_reads: got %0d want 0", rd_q.size()); end
        total++;
        if (first_valid_cyc != start_cyc + 1) begin
            bad++;
            $display("FAIL unmasked_latency: got %0d want 1", first_valid_cyc - start_cyc);
        end
    endtask

    task automatic test_vl0();
        clear_mon();
        start_pass(0, 1'b0);
        wait_done(10);
        total++;
        if (done_cyc != start_cyc + 1) begin
            bad++;
            $display("FAIL vl0_done_time: got %0d want 1", done_cyc - start_cyc);
        end
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL vl0_done_width: got %0d want 1", done_cnt); end
        total++;
        if (rd_q.size() != 0 || obs_q.size() != 0 || first_valid_cyc != -1) begin
            bad++;
            $display("FAIL vl0_activity: got reads=%0d beats=%0d want 0 0", rd_q.size(), obs_q.size());
        end
        total++;
        if (popc !== 9'd0) begin bad++; $display("FAIL vl0_popc: got %0d want 0", popc); end
    endtask

    task automatic test_masked();
        mem[0] = 32'h0000_00A5;
        clear_mon();
        start_pass(8, 1'b0);
        wait_done(50);
        exp_q.push_back(mk_beat(1'b0, 4'b0101, 0, 1, 1, 2, 0));
        exp_q.push_back(mk_beat(1'b1, 4'b1010, 2, 2, 3, 3, 4));
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL masked_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            total++;
            if (obs_q[k] !== exp_q[k]) begin
                bad++;
                $display("FAIL masked_beat%0d: got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
        total++;
        if (popc !== 9'd4) begin bad++; $display("FAIL masked_popc: got %0d want 4", popc); end
        total++;
        if (rd_q.size() != 1 || rd_q[0] != 0) begin
            bad++;
            $display("FAIL masked_reads: got count %0d want single read of 0", rd_q.size());
        end
        total++;
        if (first_valid_cyc != start_cyc + 3) begin
            bad++;
            $display("FAIL masked_latency: got %0d want 3", first_valid_cyc - start_cyc);
        end
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL masked_done_width: got %0d want 1", done_cnt); end
    endtask

    task automatic test_stall();
        logic [BW-1:0] held;
        mem[0] = 32'h0000_00A5;
        clear_mon();
        start_pass(8, 1'b0);
        wait_valid(20);
        tick();
        bus.out_ready = 1'b0;
        held = mk_beat(1'b1, 4'b1010, 2, 2, 3, 3, 4);
        for (int s = 0; s < 5; s++) begin
            total++;
            if (!bus.out_valid ||
                {bus.out_last, bus.out_mask, bus.out_iota, bus.out_offset} !== held) begin
                bad++;
                $display("FAIL stall_hold%0d: got v=%b %h want v=1 %h", s, bus.out_valid,
                         {bus.out_last, bus.out_mask, bus.out_iota, bus.out_offset}, held);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        wait_done(50);
        exp_q.push_back(mk_beat(1'b0, 4'b0101, 0, 1, 1, 2, 0));
        exp_q.push_back(held);
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL stall_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            total++;
            if (obs_q[k] !== exp_q[k]) begin
                bad++;
                $display("FAIL stall_beat%0d: got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
        total++;
        if (popc !== 9'd4) begin bad++; $display("FAIL stall_popc: got %0d want 4", popc); end
    endtask

    task automatic test_two_words();
        mem[0] = 32'hFFFF_FFFF;
        mem[1] = 32'h0000_0001;
        clear_mon();
        start_pass(40, 1'b0);
        wait_valid(20);
        tick();
        // a second start mid-pass must be ignored
        vl = '0;
        vm = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(100);
        for (int b = 0; b < 8; b++)
            exp_q.push_back(mk_beat(1'b0, 4'b1111, 4*b, 4*b + 1, 4*b + 2, 4*b + 3, 4*b));
        exp_q.push_back(mk_beat(1'b0, 4'b0001, 32, 33, 33, 33, 32));
        exp_q.push_back(mk_beat(1'b1, 4'b0000, 33, 33, 33, 33, 36));
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL two_words_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            total++;
            if (obs_q[k] !== exp_q[k]) begin
                bad++;
                $display("FAIL two_words_beat%0d: got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
        total++;
        if (popc !== 9'd33) begin bad++; $display("FAIL two_words_popc: got %0d want 33", popc); end
        total++;
        if (rd_q.size() != 2 || rd_q[0] != 0 || rd_q[1] != 1) begin
            bad++;
            $display("FAIL two_words_reads: got count %0d want reads 0 then 1", rd_q.size());
        end
        total++;
        if (beat_cyc_q.size() < 9) begin
            bad++;
            $display("FAIL two_words_gap: got %0d beats want at least 9", beat_cyc_q.size());
        end else if (beat_cyc_q[8] - beat_cyc_q[7] - 1 != EXP_GAP) begin
            bad++;
            $display("FAIL two_words_gap: got %0d want %0d",
                     beat_cyc_q[8] - beat_cyc_q[7] - 1, EXP_GAP);
        end
    endtask

    task automatic test_abort();
        mem[0] = 32'h0000_00A5;
        clear_mon();
        start_pass(8, 1'b0);
        wait_valid(20);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0 || dbg_state !== IDLE) begin
            bad++;
            $display("FAIL abort_idle: got busy=%b valid=%b state=%0d want 0 0 IDLE",
                     busy, bus.out_valid, dbg_state);
        end
        tick(); tick(); tick();
        total++;
        if (done_cnt != 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
        total++;
        if (popc !== 9'd33) begin bad++; $display("FAIL abort_popc_kept: got %0d want 33", popc); end
        // abort and start in the same idle cycle: abort wins
        vl = 9'd8;
        vm = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_start_same: got busy=%b want 0", busy); end
        clear_mon();
        start_pass(8, 1'b0);
        wait_done(50);
        exp_q.push_back(mk_beat(1'b0, 4'b0101, 0, 1, 1, 2, 0));
        exp_q.push_back(mk_beat(1'b1, 4'b1010, 2, 2, 3, 3, 4));
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL after_abort_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            total++;
            if (obs_q[k] !== exp_q[k]) begin
                bad++;
                $display("FAIL after_abort_beat%0d: got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
        total++;
        if (popc !== 9'd4) begin bad++; $display("FAIL after_abort_popc: got %0d want 4", popc); end
    endtask

    initial begin
        bus.out_ready = 1'b1;
        clear_mon();
        test_reset();
        test_unmasked();
        test_vl0();
        test_masked();
        test_stall();
        test_two_words();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
